// File: rtl/ddr2_dp_pkg.sv
// Shared definitions for the DDR2 DQ read-capture datapath controllers:
// tap command encodings, default tap geometry and the tap FSM states.
package ddr2_dp_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_SET   = 2'b11
  } op_e;

  localparam int TAP_W_DFLT = 6;
  localparam int TAP_MAX    = (1 << TAP_W_DFLT) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_STEP,
    ST_SETTLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ddr2_idelay_tap_cnt.sv
// Per-bit shadow of one IDELAY tap: saturating up/down counter with a
// synchronous clear. It follows the rst/ce/inc pulses actually sent to the IOB.
module ddr2_idelay_tap_cnt #(
  parameter int TAP_W = 6
) (
  input  logic             clk,
  input  logic             reset0_n,
  input  logic             i_clr,
  input  logic             i_ce,
  input  logic             i_inc,
  output logic [TAP_W-1:0] o_tap,
  output logic             o_at_max,
  output logic             o_at_min
);

  logic [TAP_W-1:0] r_tap;

  // Track the tap: clear on rst pulse, otherwise step on ce without wrapping.
  // NOTE: the tracked tap is async-reset because the IOB delay line is reset
  // by the same event; without it the shadow would disagree with hardware.
  always_ff @(posedge clk or negedge reset0_n) begin
    if (!reset0_n) begin
      r_tap <= '0;
    end else if (i_clr) begin
      r_tap <= '0;
    end else if (i_ce) begin
      // NOTE: non-blocking assignment keeps every register update on the same
      // clock edge, so readers in other always blocks see the old value.
      if (i_inc && !o_at_max) begin
        r_tap <= r_tap + TAP_W'(1);
      end else if (!i_inc && !o_at_min) begin
        r_tap <= r_tap - TAP_W'(1);
      end
    end
  end

  assign o_tap    = r_tap;
  assign o_at_max = (r_tap == '1);
  assign o_at_min = (r_tap == '0);

endmodule

// File: rtl/ddr2_dq_idelay_tap_ctrl.sv
// DQ input-delay tap sequencer: turns reset/inc/dec/set tap commands from the
// read-calibration logic into single-cycle rst/ce/inc pulse trains for the DQ
// IOBs, keeps a shadow of every bit's tap and flags saturation.
module ddr2_dq_idelay_tap_ctrl
  import ddr2_dp_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int TAP_W      = TAP_W_DFLT,
  parameter  int SETTLE_CYC = 3,
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset0_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_all,
  input  logic [IDX_W-1:0]      cmd_bit,
  input  logic [TAP_W-1:0]      cmd_taps,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] data_idelay_rst,
  output logic [DATA_WIDTH-1:0] data_idelay_ce,
  output logic [DATA_WIDTH-1:0] data_idelay_inc,
  output logic [DATA_WIDTH-1:0] delay_enable,
  input  logic [IDX_W-1:0]      tap_rd_bit,
  output logic [TAP_W-1:0]      tap_rd_value
);

  // Settle counter holds SETTLE_CYC-1 down to 0.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e                r_state;
  op_e                   r_op;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [TAP_W-1:0]      r_steps;
  logic [SET_W-1:0]      r_settle;
  logic                  r_sticky;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rst;
  logic [DATA_WIDTH-1:0] r_ce;
  logic [DATA_WIDTH-1:0] r_inc;
  logic [DATA_WIDTH-1:0] r_den;

  op_e                   w_cmd_op;
  logic [DATA_WIDTH-1:0] w_cmd_mask;
  logic                  w_cmd_oor;
  logic [DATA_WIDTH-1:0] w_at_max;
  logic [DATA_WIDTH-1:0] w_at_min;
  logic [TAP_W-1:0]      w_tap [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] w_acc_lim;
  logic [DATA_WIDTH-1:0] w_acc_go;
  logic                  w_acc_sat;
  logic [DATA_WIDTH-1:0] w_run_lim;
  logic [DATA_WIDTH-1:0] w_run_go;
  logic                  w_run_sat;

  assign w_cmd_op = op_e'(cmd_op);

  // Decode the target mask; an out-of-range single bit targets nothing.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_cmd_mask = '0;
    w_cmd_oor  = 1'b0;
    if (cmd_all) begin
      w_cmd_mask = '1;
    end else if (32'(cmd_bit) < 32'(DATA_WIDTH)) begin
      w_cmd_mask = DATA_WIDTH'(1) << cmd_bit;
    end else begin
      w_cmd_oor = 1'b1;
    end
  end

  // Bits at their limit in the step direction get no ce pulse. The first step
  // of INC/DEC is decided in the acceptance cycle from the incoming fields.
  assign w_acc_lim = (w_cmd_op == OP_DEC) ? w_at_min : w_at_max;
  assign w_acc_go  = w_cmd_mask & ~w_acc_lim;
  assign w_acc_sat = |(w_cmd_mask & w_acc_lim);
  assign w_run_lim = (r_op == OP_DEC) ? w_at_min : w_at_max;
  assign w_run_go  = r_mask & ~w_run_lim;
  assign w_run_sat = |(r_mask & w_run_lim);

  // Command sequencer: acceptance, RST pulse, STEP/SETTLE loop, DONE pulse.
  always_ff @(posedge clk or negedge reset0_n) begin
    if (!reset0_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_RESET;
      r_mask      <= '0;
      r_steps     <= '0;
      r_settle    <= '0;
      r_sticky    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rst       <= '0;
      r_ce        <= '0;
      r_inc       <= '0;
      r_den       <= '0;
    end else begin
      // Pulse outputs are high for exactly one cycle unless re-armed below.
      r_rst  <= '0;
      r_ce   <= '0;
      r_inc  <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op        <= w_cmd_op;
            r_mask      <= w_cmd_mask;
            r_sticky    <= w_cmd_oor;
            r_steps     <= cmd_taps;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_cmd_op == OP_RESET || w_cmd_op == OP_SET) begin
              r_state <= ST_RST;
              r_rst   <= w_cmd_mask;
            end else if (cmd_taps == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= w_cmd_oor;
            end else begin
              r_state  <= ST_STEP;
              r_ce     <= w_acc_go;
              r_inc    <= (w_cmd_op == OP_INC) ? w_acc_go : '0;
              r_sticky <= w_cmd_oor | w_acc_sat;
              r_steps  <= cmd_taps - TAP_W'(1);
            end
          end
        end
        ST_RST: begin
          if (r_op == OP_RESET) begin
            r_den   <= r_den & ~r_mask;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= r_sticky;
          end else if (r_steps == '0) begin
            r_den   <= r_den | r_mask;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= r_sticky;
          end else begin
            // Targets were just cleared to tap 0, so none can be at the top.
            r_state <= ST_STEP;
            r_ce    <= r_mask;
            r_inc   <= r_mask;
            r_steps <= r_steps - TAP_W'(1);
          end
        end
        ST_STEP: begin
          r_state  <= ST_SETTLE;
          r_settle <= SET_W'(SETTLE_CYC - 1);
        end
        ST_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - SET_W'(1);
          end else if (r_steps != '0) begin
            r_state  <= ST_STEP;
            r_ce     <= w_run_go;
            r_inc    <= (r_op == OP_DEC) ? '0 : w_run_go;
            r_sticky <= r_sticky | w_run_sat;
            r_steps  <= r_steps - TAP_W'(1);
          end else begin
            if (r_op == OP_SET) begin
              r_den <= r_den | r_mask;
            end
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_err   <= r_sticky;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_err       <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // One shadow tap counter per DQ bit, driven by the pulses sent to the IOB.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_tap
    ddr2_idelay_tap_cnt #(
      .TAP_W (TAP_W)
    ) u_tap_cnt (
      .clk      (clk),
      .reset0_n (reset0_n),
      .i_clr    (r_rst[g]),
      .i_ce     (r_ce[g]),
      .i_inc    (r_inc[g]),
      .o_tap    (w_tap[g]),
      .o_at_max (w_at_max[g]),
      .o_at_min (w_at_min[g])
    );
  end

  // Tap readback mux; an unused select value reads as tap 0.
  always_comb begin
    tap_rd_value = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (32'(tap_rd_bit) == 32'(i)) begin
        tap_rd_value = w_tap[i];
      end
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign data_idelay_rst = r_rst;
  assign data_idelay_ce  = r_ce;
  assign data_idelay_inc = r_inc;
  assign delay_enable    = r_den;

endmodule

// File: tb/tb_ddr2_dq_idelay_tap_ctrl.sv
// Scoreboard bench for the DQ tap sequencer. The stimulus process issues
// commands and pushes the response predicted by a tap-arithmetic model; the
// monitor process watches the pulse buses and compares at every done pulse.
// A 6-bit DQ width is used so the 3-bit bit index can address absent bits.
`timescale 1ns/1ps
module tb_ddr2_dq_idelay_tap_ctrl;
  import ddr2_dp_pkg::*;

  localparam int DW    = 6;
  localparam int TAP_W = 6;
  localparam int S     = 3;
  localparam int IDX_W = 3;
  localparam int TMAX  = (1 << TAP_W) - 1;
  localparam int PER   = 1 + S;

  logic             clk = 1'b0;
  logic             reset0_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic             cmd_all = 1'b0;
  logic [IDX_W-1:0] cmd_bit = '0;
  logic [TAP_W-1:0] cmd_taps = '0;
  logic             busy, done, err;
  logic [DW-1:0]    data_idelay_rst, data_idelay_ce, data_idelay_inc, delay_enable;
  logic [IDX_W-1:0] tap_rd_bit;
  logic [TAP_W-1:0] tap_rd_value;

  always #5 clk = ~clk;

  ddr2_dq_idelay_tap_ctrl #(
    .DATA_WIDTH (DW),
    .TAP_W      (TAP_W),
    .SETTLE_CYC (S)
  ) u_dut (
    .clk             (clk),
    .reset0_n        (reset0_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_all         (cmd_all),
    .cmd_bit         (cmd_bit),
    .cmd_taps        (cmd_taps),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .data_idelay_rst (data_idelay_rst),
    .data_idelay_ce  (data_idelay_ce),
    .data_idelay_inc (data_idelay_inc),
    .delay_enable    (delay_enable),
    .tap_rd_bit      (tap_rd_bit),
    .tap_rd_value    (tap_rd_value)
  );

  typedef struct packed {
    int                        acc_cyc;
    int                        lat;
    int                        ce_off;
    logic                      err;
    logic                      dir_inc;
    logic [DW-1:0]             den;
    logic [DW-1:0]             rst_mask;
    logic [DW-1:0][7:0]        ce_cnt;
    logic [DW-1:0][TAP_W-1:0]  taps;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            acc_count = 0;
  int            rst_chk_req = 0;
  int            rst_chk_done = 0;
  int            m_tap [DW];
  logic [DW-1:0] m_den = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tap arithmetic on a per-bit array, one entry per command.
  task automatic model_push(input op_e op, input logic all, input int bitn,
                            input int n, input int acc);
    exp_t          e;
    logic [DW-1:0] t;
    int            room, c;
    e = '0;
    e.acc_cyc = acc;
    e.dir_inc = (op != OP_DEC);
    e.err     = !all && (bitn >= DW);
    t = '0;
    for (int i = 0; i < DW; i++) if (all || i == bitn) t[i] = 1'b1;
    case (op)
      OP_RESET: begin
        e.lat = 2;
        e.rst_mask = t;
        for (int i = 0; i < DW; i++) if (t[i]) m_tap[i] = 0;
        m_den = m_den & ~t;
      end
      OP_SET: begin
        e.lat = 2 + n * PER;
        e.rst_mask = t;
        e.ce_off = 2;
        for (int i = 0; i < DW; i++) if (t[i]) begin
          m_tap[i] = n;
          e.ce_cnt[i] = 8'(n);
        end
        m_den = m_den | t;
      end
      default: begin
        e.lat = 1 + n * PER;
        e.ce_off = 1;
        for (int i = 0; i < DW; i++) if (t[i]) begin
          room = (op == OP_INC) ? TMAX - m_tap[i] : m_tap[i];
          c = (n < room) ? n : room;
          if (n > room) e.err = 1'b1;
          m_tap[i] = (op == OP_INC) ? m_tap[i] + c : m_tap[i] - c;
          e.ce_cnt[i] = 8'(c);
        end
      end
    endcase
    e.den = m_den;
    for (int i = 0; i < DW; i++) e.taps[i] = TAP_W'(m_tap[i]);
    sb_q.push_back(e);
  endtask

  // Monitor: accumulates pulse activity per command and scores it at done.
  int            ce_act [DW];
  int            ce_first [DW];
  int            last_ce [DW];
  logic [DW-1:0] rst_seen;
  int            rst_cyc, dir_bad, space_bad;

  initial begin : monitor
    exp_t e;
    tap_rd_bit = '0;
    rst_seen = '0;
    rst_cyc = 0;
    dir_bad = 0;
    space_bad = 0;
    for (int i = 0; i < DW; i++) begin
      ce_act[i] = 0;
      ce_first[i] = 0;
      last_ce[i] = -1000;
    end
    forever begin
      @(negedge clk);
      if (rst_chk_req != rst_chk_done) begin
        check("rst_state_ready", int'(cmd_ready), 1);
        check("rst_state_busy", int'(busy), 0);
        check("rst_state_done", int'(done), 0);
        check("rst_state_err", int'(err), 0);
        check("rst_state_rst", int'(data_idelay_rst), 0);
        check("rst_state_ce", int'(data_idelay_ce), 0);
        check("rst_state_inc", int'(data_idelay_inc), 0);
        check("rst_state_den", int'(delay_enable), 0);
        for (int i = 0; i < DW; i++) begin
          tap_rd_bit = IDX_W'(i);
          #0.1;
          check($sformatf("rst_state_tap[%0d]", i), int'(tap_rd_value), 0);
        end
        rst_chk_done++;
      end
      if (!reset0_n) begin
        for (int i = 0; i < DW; i++) last_ce[i] = -1000;
        continue;
      end
      if (cmd_valid && cmd_ready) begin
        acc_count++;
        rst_seen = '0;
        dir_bad = 0;
        space_bad = 0;
        for (int i = 0; i < DW; i++) ce_act[i] = 0;
      end
      if (data_idelay_rst != '0) begin
        rst_seen = rst_seen | data_idelay_rst;
        rst_cyc = cyc;
      end
      for (int i = 0; i < DW; i++) begin
        if (data_idelay_ce[i]) begin
          if (sb_q.size() == 0) check("ce_without_cmd", 1, 0);
          else if (data_idelay_inc[i] !== sb_q[0].dir_inc) dir_bad++;
          if (cyc - last_ce[i] < PER) space_bad++;
          last_ce[i] = cyc;
          if (ce_act[i] == 0) ce_first[i] = cyc;
          ce_act[i]++;
        end
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_without_cmd", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc - e.acc_cyc, e.lat);
          check("err", int'(err), int'(e.err));
          check("busy_at_done", int'(busy), 1);
          check("ready_at_done", int'(cmd_ready), 0);
          check("delay_enable", int'(delay_enable), int'(e.den));
          check("rst_mask", int'(rst_seen), int'(e.rst_mask));
          if (e.rst_mask != '0) check("rst_offset", rst_cyc - e.acc_cyc, 1);
          check("inc_dir_errors", dir_bad, 0);
          check("ce_spacing_errors", space_bad, 0);
          for (int i = 0; i < DW; i++) begin
            check($sformatf("ce_count[%0d]", i), ce_act[i], int'(e.ce_cnt[i]));
            if (ce_act[i] > 0 && e.ce_cnt[i] != 8'd0)
              check($sformatf("ce_first[%0d]", i), ce_first[i] - e.acc_cyc, e.ce_off);
          end
          for (int i = 0; i < DW; i++) begin
            tap_rd_bit = IDX_W'(i);
            #0.1;
            check($sformatf("tap[%0d]", i), int'(tap_rd_value), int'(e.taps[i]));
          end
        end
      end
    end
  end

  // Issue one command; optionally hold cmd_valid through busy and/or wait for done.
  task automatic issue(input op_e op, input logic all, input int bitn, input int n,
                       input bit hold, input bit wait_done);
    int waited;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_all   = all;
    cmd_bit   = IDX_W'(bitn);
    cmd_taps  = TAP_W'(n);
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!cmd_ready && waited < 50);
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    model_push(op, all, bitn, n, cyc);
    if (!hold) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    if (!wait_done) return;
    waited = 0;
    while (sb_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
    end
    if (hold) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic reset_check();
    int waited;
    rst_chk_req++;
    waited = 0;
    while (rst_chk_done != rst_chk_req && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (rst_chk_done != rst_chk_req) check("reset_check_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   a0;
    op_e  op;
    logic all;
    int   bitn, n;
    for (int i = 0; i < DW; i++) m_tap[i] = 0;
    reset_check();
    @(negedge clk);
    #1;
    reset0_n = 1'b1;

    issue(OP_INC,   1'b1, 0, 2,  1'b0, 1'b1);   // ce all at 1,5; done 9
    issue(OP_RESET, 1'b1, 0, 0,  1'b0, 1'b1);
    issue(OP_SET,   1'b0, 2, 3,  1'b0, 1'b1);   // rst 1, ce 2,6,10; done 14
    issue(OP_SET,   1'b0, 0, 3,  1'b0, 1'b1);
    issue(OP_DEC,   1'b0, 0, 5,  1'b0, 1'b1);   // 3 pulses, done 21, err
    issue(OP_SET,   1'b0, 5, 63, 1'b0, 1'b1);
    issue(OP_INC,   1'b0, 5, 1,  1'b0, 1'b1);   // saturated, done 5, err
    issue(OP_INC,   1'b0, 7, 1,  1'b0, 1'b1);   // absent bit
    issue(OP_SET,   1'b0, 6, 4,  1'b0, 1'b1);   // absent bit
    issue(OP_RESET, 1'b0, 7, 0,  1'b0, 1'b1);   // absent bit
    issue(OP_INC,   1'b0, 3, 0,  1'b0, 1'b1);   // zero steps
    issue(OP_SET,   1'b1, 0, 0,  1'b0, 1'b1);   // zero-step set

    a0 = acc_count;
    issue(OP_INC, 1'b0, 1, 2, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("held_valid_accepts", acc_count - a0, 1);

    issue(OP_SET, 1'b1, 0, 10, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    #1;
    reset0_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DW; i++) m_tap[i] = 0;
    m_den = '0;
    reset_check();
    repeat (2) @(negedge clk);
    #1;
    reset0_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      op   = op_e'($urandom_range(0, 3));
      all  = ($urandom_range(0, 3) == 0);
      bitn = $urandom_range(0, 7);
      n    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 63);
      issue(op, all, bitn, n, 1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
